// File: rtl/stream_beat_packer_pkg.sv
// Shared definitions for the beat packer and the planned beat unpacker.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package stream_beat_packer_pkg;

   // FILL collects beats; FULL presents a word downstream (out_valid=1).
   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } pack_state_t;

   // Width needed to hold a lane count of 0..ratio.
   function automatic int cnt_width(input int ratio);
      return $clog2(ratio + 1);
   endfunction

   // Bit offset of a lane inside a packed word; lane 0 sits in the LSBs.
   function automatic int lane_offset(input int lane, input int lane_width);
      return lane * lane_width;
   endfunction

endpackage

// File: rtl/stream_beat_packer.sv
// Valid/ready upsizer: packs RATIO narrow beats into one wide word, flushing early on in_last.
// Latency: word is valid one cycle after its completing beat is accepted.
// Backpressure: in_ready = !out_valid | out_ready; a held word stalls input, a draining word accepts a beat the same cycle.
module stream_beat_packer
   import stream_beat_packer_pkg::*;
#(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4,
   localparam int OUT_WIDTH = IN_WIDTH * RATIO,
   localparam int CNT_W     = cnt_width(RATIO)
) (
   input  logic                 clk,
   input  logic                 resetn,
   output logic                 in_ready,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_last,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last,
   output logic [CNT_W-1:0]     out_count
);

   generate
      if (RATIO < 2) begin : g_bad_ratio
         $error("stream_beat_packer: RATIO must be >= 2");
      end
   endgenerate

   pack_state_t            state_q, state_d;
   logic [OUT_WIDTH-1:0]   data_q, data_d;
   logic                   last_q, last_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [CNT_W-1:0]       idx_q, idx_d;
   logic                   accept;

   // While a word is held, idx is always 0, so a beat accepted during the
   // output transfer naturally starts a fresh word in lane 0.
   assign in_ready  = (state_q == FILL) | out_ready;
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_last  = last_q;
   assign out_count = count_q;

   // Next-state and datapath: lane write, completion detection, drain.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      last_d  = last_q;
      count_d = count_q;
      idx_d   = idx_q;
      if (accept) begin
         // Starting a word clears the upper lanes so partial words read 0 there.
         if (idx_q == '0) begin
            data_d = '0;
         end
         for (int k = 0; k < RATIO; k++) begin
            if (idx_q == CNT_W'(k)) begin
               data_d[lane_offset(k, IN_WIDTH) +: IN_WIDTH] = in_data;
            end
         end
         if ((idx_q == CNT_W'(RATIO - 1)) || in_last) begin
            state_d = FULL;
            count_d = idx_q + CNT_W'(1);
            last_d  = in_last;
            idx_d   = '0;
         end else begin
            state_d = FILL;
            idx_d   = idx_q + CNT_W'(1);
         end
      end else if ((state_q == FULL) && out_ready) begin
         state_d = FILL;
      end
   end

   // State and datapath registers; reset discards any partial word.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= FILL;
         data_q  <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         last_q  <= last_d;
         count_q <= count_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_stream_beat_packer.sv
// Self-checking bench for stream_beat_packer: queue-based word model plus directed literal checks.
// Latency: model expects a word on the cycle after its completing beat.
// Backpressure: random out_ready stalls exercise hold and simultaneous drain/fill.
module tb_stream_beat_packer;

   localparam int IW = 8;
   localparam int R  = 4;
   localparam int OW = IW * R;
   localparam int CW = $clog2(R + 1);

   logic          clk = 1'b0;
   logic          resetn;
   logic          in_ready;
   logic          in_valid;
   logic [IW-1:0] in_data;
   logic          in_last;
   logic          out_ready;
   logic          out_valid;
   logic [OW-1:0] out_data;
   logic          out_last;
   logic [CW-1:0] out_count;

   stream_beat_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_ready  (in_ready),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_words = 0;

   typedef struct {
      logic [OW-1:0] data;
      int            count;
      logic          last;
   } word_t;

   logic [IW-1:0] cur_q[$];
   word_t         exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: collect accepted beats; a word is due when RATIO beats or in_last arrive.
   always @(negedge clk) begin
      if (!resetn) begin
         cur_q.delete();
         exp_q.delete();
         check("rst_out_valid", {63'd0, out_valid}, 64'd0);
         check("rst_out_data", {32'd0, out_data}, 64'd0);
         check("rst_out_count", {61'd0, out_count}, 64'd0);
         check("rst_out_last", {63'd0, out_last}, 64'd0);
      end else begin
         check("m_out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
         check("m_in_ready", {63'd0, in_ready}, {63'd0, (exp_q.size() == 0) || out_ready});
         if (out_valid && exp_q.size() != 0) begin
            check("m_out_data", {32'd0, out_data}, {32'd0, exp_q[0].data});
            check("m_out_count", {61'd0, out_count}, 64'(exp_q[0].count));
            check("m_out_last", {63'd0, out_last}, {63'd0, exp_q[0].last});
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n_words++;
         end
         if (in_valid && in_ready) begin
            cur_q.push_back(in_data);
            if (cur_q.size() == R || in_last) begin
               word_t w;
               w.data = '0;
               for (int i = 0; i < cur_q.size(); i++) w.data[i*IW +: IW] = cur_q[i];
               w.count = cur_q.size();
               w.last  = in_last;
               exp_q.push_back(w);
               cur_q.delete();
            end
         end
      end
   end

   // One clock of stimulus; entered and left at posedge+1.
   task automatic cycle(input logic v, input logic [IW-1:0] d, input logic l, input logic r,
                        output logic acc, output logic rdy);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = r;
      @(negedge clk);
      rdy = in_ready;
      acc = v && in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [IW-1:0] d, input logic l, input logic r);
      logic acc, rdy;
      int   n;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 20) begin
         cycle(1'b1, d, l, r, acc, rdy);
         n++;
      end
      if (!acc) begin
         n_err++;
         $display("FAIL send_timeout: beat 0x%0h not accepted within 20 cycles", d);
      end
      in_valid = 1'b0;
   endtask

   task automatic expect_word(input string name, input logic [OW-1:0] d, input int c, input logic l);
      check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
      check({name, "_data"}, {32'd0, out_data}, {32'd0, d});
      check({name, "_count"}, {61'd0, out_count}, 64'(c));
      check({name, "_last"}, {63'd0, out_last}, {63'd0, l});
   endtask

   initial begin
      logic acc, rdy;
      int   w0;
      resetn = 1'b0; in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      #1 resetn = 1'b1; in_valid = 1'b0;

      // Full word of 4 beats.
      send(8'h11, 1'b0, 1'b1); send(8'h22, 1'b0, 1'b1);
      send(8'h33, 1'b0, 1'b1); send(8'h44, 1'b0, 1'b1);
      expect_word("full4", 32'h44332211, 4, 1'b0);

      // Early flush on in_last; first beat rides the previous word's drain.
      send(8'h11, 1'b0, 1'b1); send(8'h22, 1'b1, 1'b1);
      expect_word("flush2", 32'h00002211, 2, 1'b1);

      // Hold under backpressure, then accept 0xAA during the drain.
      send(8'h01, 1'b0, 1'b1); send(8'h02, 1'b0, 1'b0);
      send(8'h03, 1'b0, 1'b0); send(8'h04, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 8'hAA, 1'b0, 1'b0, acc, rdy);
         check("hold_in_ready", {63'd0, rdy}, 64'd0);
         check("hold_data", {32'd0, out_data}, 64'h04030201);
      end
      cycle(1'b1, 8'hAA, 1'b0, 1'b1, acc, rdy);
      check("drain_accept", {63'd0, acc}, 64'd1);
      send(8'hBB, 1'b1, 1'b0);
      expect_word("aa_lane0", 32'h0000BBAA, 2, 1'b1);

      // Single last beat accepted with the prior word's transfer: no bubble.
      cycle(1'b0, 8'h00, 1'b0, 1'b0, acc, rdy);
      cycle(1'b1, 8'h5A, 1'b1, 1'b1, acc, rdy);
      check("single_accept", {63'd0, acc}, 64'd1);
      expect_word("single", 32'h0000005A, 1, 1'b1);

      // 12 back-to-back beats at full rate.
      w0 = n_words;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b1, acc, rdy);
         check("stream_in_ready", {63'd0, rdy}, 64'd1);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1, acc, rdy);
      check("stream_words", 64'(n_words - w0), 64'd4);

      // Reset mid-word discards the partial word.
      send(8'hC1, 1'b0, 1'b1); send(8'hC2, 1'b0, 1'b1);
      #2 resetn = 1'b0;
      #1 check("midrst_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_data", {32'd0, out_data}, 64'd0);
      @(posedge clk);
      #1 resetn = 1'b1;
      send(8'h01, 1'b0, 1'b1); send(8'h02, 1'b0, 1'b1);
      send(8'h03, 1'b0, 1'b1); send(8'h04, 1'b0, 1'b1);
      expect_word("post_rst", 32'h04030201, 4, 1'b0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 5) == 0, ($urandom % 3) != 0, acc, rdy);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1, acc, rdy);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, acc, rdy);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stream_beat_packer.md
Name: stream_beat_packer

Overview:
- Valid/ready width upsizer. Collects RATIO narrow input beats into one wide output word.
- Sits directly upstream of the single-stage pipeline register and drives its in_valid/in_data/in_ready handshake.
- Supports early flush on in_last so that packet tails emit a partial word with a lane count.

Parameters:
- IN_WIDTH, 8, width of one input beat in bits.
- RATIO, 4, beats per output word. Legal range is RATIO >= 2; an elaboration-time assertion rejects anything else.
- OUT_WIDTH, IN_WIDTH*RATIO, derived localparam. Not overridable.
- CNT_W, $clog2(RATIO+1), derived localparam. Width of out_count.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_ready  output  1  upstream may transfer this cycle.
- in_valid  input  1  upstream beat valid.
- in_data  input  IN_WIDTH  beat payload.
- in_last  input  1  final beat of packet; forces word emission.
- out_ready  input  1  downstream accepts word.
- out_valid  output  1  word valid.
- out_data  output  OUT_WIDTH  packed word. Lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- out_last  output  1  word contains the packet's final beat.
- out_count  output  CNT_W  number of valid lanes, 1..RATIO.

Behaviour:
- Clock and reset: clock clk; reset resetn, asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_last=0, out_count=0, internal lane index=0.
  - in_ready is combinational and reads 1 while reset is asserted, but no beat is captured during reset.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = !out_valid | out_ready. in_ready must not depend on in_valid.
- State machine, two states derived from out_valid:
  - FILL (out_valid=0): each accepted beat is written to lane[idx], then idx increments.
    - If idx==RATIO-1 or in_last=1 on the accepted beat: next cycle out_valid=1, out_count=idx+1, out_last=in_last, idx returns to 0 -> FULL.
  - FULL (out_valid=1): out_data, out_last and out_count are held stable until out_ready=1.
    - On an output transfer with no simultaneous input: next cycle out_valid=0 -> FILL.
- Simultaneous output transfer and input beat in FULL:
  - The beat is accepted into lane 0 of a fresh word, with all other lanes cleared to 0.
  - out_valid=0 next cycle, unless RATIO completion or in_last applies to that beat. That cannot happen for RATIO>=2 unless in_last=1, in which case out_valid stays 1 with out_count=1.
  - No bubble is allowed.
- Lane contents:
  - Writing lane 0 clears lanes 1..RATIO-1, so unused lanes of a partial word always read 0.
  - Lane 0 holds the first beat, in the LSBs.
- Latency: the word appears one cycle after its completing beat is accepted.
- Throughput: one output word per RATIO input cycles at full rate.
- Beats held off by backpressure are not dropped.
- in_data/in_last are ignored when in_valid=0.
- Reset mid-word discards the partial word; the next accepted beat lands in lane 0.
- All arithmetic on idx is unsigned CNT_W bits with explicit wrap to 0. No overflow is possible.

Decomposition:
- Shared package: a function computing CNT_W, and a lane-select helper (lane index to bit offset).
- Both are reused by the planned downstream beat unpacker.
- Single flat module. No sub-module is warranted.

Test Plan:
- 4 beats 0x11,0x22,0x33,0x44 (in_last on beat 4 = 0), out_ready=1 -> one cycle after beat 4: out_valid=1, out_data=0x44332211, out_count=4, out_last=0.
- Beats 0x11,0x22 with in_last=1 on 0x22 -> out_data=0x00002211, out_count=2, out_last=1. The next word starts at lane 0.
- Full word held while out_ready=0 for 3 cycles -> in_ready=0 and out_data stable for all 3 cycles. On out_ready=1, beat 0xAA is accepted in the same cycle; the next word's lane 0 = 0xAA.
- 12 continuous beats with in_valid=1 and out_ready=1 -> 3 words with no idle input cycle and in_ready=1 throughout.
- Single beat 0x5A with in_last=1 accepted in the same cycle as a prior word's transfer -> out_valid stays 1, out_data=0x0000005A, out_count=1, out_last=1.
- 2 beats accepted, then resetn pulsed low mid-cycle -> out_valid=0 immediately. The subsequent 4 beats 0x01..0x04 yield 0x04030201 with count 4.
